// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the 1011 sequence detector.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out
// one bit per bit-period (CYCLES_PER_BIT clocks), MSB- or LSB-first, with an
// optional forced idle gap of GAP_CYCLES clocks between words.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   s_data    in   word to serialize (sampled only at accept)
//   s_valid   in   s_data valid
//   s_ready   out  block can accept a word this cycle (combinational)
//   abort     in   synchronous abort of the current word
//   ser_bit   out  serial bit stream, 0 whenever ser_valid=0
//   ser_valid out  ser_bit carries a word bit
//   busy      out  word in flight (SHIFT or GAP)
//   word_done out  one-clock pulse on the last clock of the last bit
module bit_serializer #(
    parameter int WIDTH          = 8,
    parameter int MSB_FIRST      = 1,
    parameter int CYCLES_PER_BIT = 1,
    parameter int GAP_CYCLES     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             abort,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic          B2B      = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [CW-1:0]    cyc_cnt, cyc_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             ser_bit_n, ser_valid_n, busy_n, word_done_n;
    logic             last_clk, accept, first_bit;

    // Final clock of the final bit of the word currently on ser_bit.
    assign last_clk = (state == S_SHIFT) && (bit_cnt == BIT_LAST) && (cyc_cnt == CYC_LAST);

    // With no gap configured, the final clock also accepts the next word so
    // ser_valid stays high across word boundaries.
    assign s_ready = rst && !abort && ((state == S_IDLE) || (B2B && last_clk));
    assign accept  = s_valid && s_ready;

    assign first_bit = (MSB_FIRST != 0) ? s_data[WIDTH-1] : s_data[0];

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_n       = bit_cnt;
        cyc_n       = cyc_cnt;
        gap_n       = gap_cnt;
        ser_bit_n   = 1'b0;
        ser_valid_n = 1'b0;
        busy_n      = 1'b0;

        if (abort) begin
            state_n = S_IDLE;
            bit_n   = '0;
            cyc_n   = '0;
            gap_n   = '0;
        end else if (accept) begin
            state_n     = S_SHIFT;
            shreg_n     = s_data;
            bit_n       = '0;
            cyc_n       = '0;
            gap_n       = '0;
            ser_bit_n   = first_bit;
            ser_valid_n = 1'b1;
            busy_n      = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_IDLE;
                end
                S_SHIFT: begin
                    if (last_clk) begin
                        bit_n = '0;
                        cyc_n = '0;
                        gap_n = '0;
                        if (B2B) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_GAP;
                            busy_n  = 1'b1;
                        end
                    end else if (cyc_cnt == CYC_LAST) begin
                        // Advance: the register is shifted so the next bit
                        // always sits at the emitting end.
                        bit_n       = bit_cnt + BW'(1);
                        cyc_n       = '0;
                        ser_valid_n = 1'b1;
                        busy_n      = 1'b1;
                        if (MSB_FIRST != 0) begin
                            shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                            ser_bit_n = shreg[WIDTH-2];
                        end else begin
                            shreg_n   = {1'b0, shreg[WIDTH-1:1]};
                            ser_bit_n = shreg[1];
                        end
                    end else begin
                        cyc_n       = cyc_cnt + CW'(1);
                        ser_bit_n   = ser_bit;
                        ser_valid_n = 1'b1;
                        busy_n      = 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = S_IDLE;
                        gap_n   = '0;
                    end else begin
                        gap_n  = gap_cnt + GW'(1);
                        busy_n = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    bit_n   = '0;
                    cyc_n   = '0;
                    gap_n   = '0;
                end
            endcase
        end

        // word_done is registered, so it is raised on entry to the last clock.
        word_done_n = (state_n == S_SHIFT) && (bit_n == BIT_LAST) && (cyc_n == CYC_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            gap_cnt   <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_n;
            cyc_cnt   <= cyc_n;
            gap_cnt   <= gap_n;
            ser_bit   <= ser_bit_n;
            ser_valid <= ser_valid_n;
            busy      <= busy_n;
            word_done <= word_done_n;
        end
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end that feeds the 1011 sequence detector (fsm_2_always) one bit per bit-period on its in_bit input. It accepts WIDTH-bit words over a valid/ready handshake. It shifts each word out MSB- or LSB-first, with optional per-bit stretching and inter-word idle gap. ser_bit connects directly to the detector's in_bit. ser_valid, busy and word_done are for the bench and for downstream qualification.

Parameters:
WIDTH, 8, bits per input word (>=2)
MSB_FIRST, 1, 1 = shift out s_data[WIDTH-1] first; 0 = s_data[0] first
CYCLES_PER_BIT, 1, clocks each bit is held on ser_bit (>=1)
GAP_CYCLES, 0, idle clocks forced between consecutive words (0 = back-to-back allowed)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
s_data  input  WIDTH  word to serialize
s_valid  input  1  s_data valid
s_ready  output  1  block can accept a word this cycle
abort  input  1  synchronous abort of current word
ser_bit  output  1  serial bit stream (to detector in_bit)
ser_valid  output  1  ser_bit carries a word bit
busy  output  1  word in flight (SHIFT or GAP)
word_done  output  1  one-clock pulse on the last clock of the last bit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit/cycle/gap counters=0. Outputs ser_bit=0, ser_valid=0, busy=0, word_done=0. s_ready is gated to 0 while rst=0.
- All outputs except s_ready are registered. s_ready is combinational from state, counters and abort.
- States:
  - IDLE: s_ready=1 unless abort=1. On s_valid&&s_ready, load s_data into the shift register and go to SHIFT. ser_bit is driven from the loaded word starting the next cycle.
  - SHIFT: ser_valid=1, busy=1. Each bit is held for exactly CYCLES_PER_BIT clocks, then the next bit is presented. After WIDTH bits, word_done=1 for exactly one clock: the final clock of bit WIDTH-1. Then go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: ser_bit=0, ser_valid=0, busy=1, s_ready=0 for exactly GAP_CYCLES clocks, then IDLE.
- Latency: word accepted at edge k, so the first bit is visible after edge k. A word occupies WIDTH*CYCLES_PER_BIT clocks on ser_bit.
- Back-to-back: if GAP_CYCLES==0, s_ready is also 1 on the final clock of the final bit. An accept there loads the next word with no bubble, and ser_valid stays 1 continuously.
- Bit order: MSB_FIRST=1 emits s_data[WIDTH-1] down to s_data[0]; MSB_FIRST=0 emits s_data[0] up to s_data[WIDTH-1].
- Idle/gap value: ser_bit=0 whenever ser_valid=0. The downstream detector sees zeros, which cannot complete 1011.
- Counters: bit counter is $clog2(WIDTH) wide and cycle counter is max(1,$clog2(CYCLES_PER_BIT)) wide. Neither wraps mid-word; both clear on load, abort and reset.
- abort=1 (any state) at an edge: go to IDLE, clear counters, ser_bit=0, ser_valid=0, busy=0. No word_done, and the partial word is discarded. abort forces s_ready=0 that cycle, so abort plus s_valid in the same cycle accepts nothing. abort on the word_done clock suppresses word_done.
- s_data is sampled only at accept. Changes afterwards are ignored.
- s_valid while not ready: the word is held by the source, not dropped. No internal buffering beyond the single shift register.
- Asynchronous reset mid-word: immediate return to reset values. The word is lost.

Test Plan:
- Reset: rst=0 for 2 clocks with s_valid=1, s_data=8'hB0. Required: s_ready=0, ser_bit=0, ser_valid=0, busy=0 throughout. After release, s_ready=1 in IDLE.
- MSB-first word: defaults, send 8'hB0. Required: ser_bit=1,0,1,1,0,0,0,0 on 8 consecutive clocks with ser_valid=1, word_done on the 8th, then IDLE. The attached detector asserts out after the 4th bit.
- Back-to-back with GAP_CYCLES=0: send 8'hB0 then 8'h0B, s_valid held high. Required: 16 contiguous ser_valid clocks, s_ready high on clock 8, two word_done pulses on clocks 8 and 16.
- Stretch/gap with CYCLES_PER_BIT=2, GAP_CYCLES=3, MSB_FIRST=0: send 8'h0D. Required: bits 1,0,1,1,0,0,0,0 each held 2 clocks (16 clocks total), then 3 clocks of ser_valid=0 with s_ready=0, then s_ready=1.
- Abort mid-word: defaults, send 8'hB0, assert abort on bit 3. Required: next clock ser_valid=0, ser_bit=0, busy=0, no word_done. Next word 8'hFF is accepted and shifts out 8 ones.
- Abort collision: abort=1 and s_valid=1 in the same IDLE cycle. Required: s_ready=0, no accept. Next cycle with abort=0, the word is accepted.
